// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the ALU compare unit: compare-select
//                field values and the position of the subtract-select bit.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Bit of i_alu_fn that selects subtract (A - B) instead of add (A + B).
    localparam int SUB_BIT = 0;

    // Compare-select field, i_alu_fn[2:1].
    typedef enum logic [1:0] {
        CMP_NONE = 2'b00,
        CMP_EQ   = 2'b01,
        CMP_LT   = 2'b10,
        CMP_LE   = 2'b11
    } cmp_sel_e;

endpackage
`default_nettype wire

// File: rtl/carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_adder
//  Description : Purely combinational adder built from 4-bit carry-lookahead
//                groups; the group carries ripple from group to group.
//  Revision    : 1.0  initial release
// ============================================================================
module carry_lookahead_adder #(
    parameter int WIDTH = 16
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGRP = WIDTH / 4;

    // w_gc[k] is the carry into group k; w_gc[NGRP] is the final carry-out.
    logic [NGRP:0] w_gc;

    assign w_gc[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_group
            logic [3:0] w_g;
            logic [3:0] w_p;
            logic [4:0] w_c;

            assign w_g = a[4*gi +: 4] & b[4*gi +: 4];
            assign w_p = a[4*gi +: 4] ^ b[4*gi +: 4];

            // Every carry inside the group is expanded directly from the
            // group carry-in, so the group adds no internal ripple.
            assign w_c[0] = w_gc[gi];
            assign w_c[1] = w_g[0]
                          | (w_p[0] & w_c[0]);
            assign w_c[2] = w_g[1]
                          | (w_p[1] & w_g[0])
                          | (w_p[1] & w_p[0] & w_c[0]);
            assign w_c[3] = w_g[2]
                          | (w_p[2] & w_g[1])
                          | (w_p[2] & w_p[1] & w_g[0])
                          | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
            assign w_c[4] = w_g[3]
                          | (w_p[3] & w_g[2])
                          | (w_p[3] & w_p[2] & w_g[1])
                          | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                          | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

            assign sum[4*gi +: 4] = w_p ^ w_c[3:0];
            assign w_gc[gi+1]     = w_c[4];
        end
    endgenerate

    assign cout = w_gc[NGRP];

endmodule
`default_nettype wire

// File: rtl/alu_compare_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_compare_unit
//  Description : Add/subtract unit with zero, overflow and negative flags
//                and a signed compare result; one registered output stage.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_compare_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_alu_fn,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_z,
    output logic             o_v,
    output logic             o_n,
    output logic             o_cmp
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum_d;
    logic             w_cout_d;
    logic             w_z_d;
    logic             w_v_d;
    logic             w_n_d;
    logic             w_lt;
    logic             w_cmp_d;
    cmp_sel_e         w_cmp_sel;

    logic             r_valid_q;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;
    logic             r_z_q;
    logic             r_v_q;
    logic             r_n_q;
    logic             r_cmp_q;

    // Subtraction is A + ~B + 1: invert B and feed the select bit as carry-in.
    assign w_sub   = i_alu_fn[SUB_BIT];
    assign w_b_eff = i_b ^ {WIDTH{w_sub}};

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .cin  (w_sub),
        .a    (i_a),
        .b    (w_b_eff),
        .sum  (w_sum_d),
        .cout (w_cout_d)
    );

    // Flags from the adder result, and the compare selected by i_alu_fn[2:1].
    always_comb begin
        w_cmp_sel = cmp_sel_e'(i_alu_fn[2:1]);
        w_z_d     = (w_sum_d == '0);
        w_n_d     = w_sum_d[WIDTH-1];
        w_v_d     = ( i_a[WIDTH-1] &  w_b_eff[WIDTH-1] & ~w_sum_d[WIDTH-1])
                  | (~i_a[WIDTH-1] & ~w_b_eff[WIDTH-1] &  w_sum_d[WIDTH-1]);
        // Signed less-than: sign of the result, corrected when it overflowed.
        w_lt      = w_n_d ^ w_v_d;
        w_cmp_d   = 1'b0;
        case (w_cmp_sel)
            CMP_EQ:  w_cmp_d = w_z_d;
            CMP_LT:  w_cmp_d = w_lt;
            CMP_LE:  w_cmp_d = w_z_d | w_lt;
            default: w_cmp_d = 1'b0;
        endcase
    end

    // Output stage: everything is captured every cycle; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
            r_z_q     <= 1'b0;
            r_v_q     <= 1'b0;
            r_n_q     <= 1'b0;
            r_cmp_q   <= 1'b0;
        end else begin
            r_valid_q <= i_valid;
            r_sum_q   <= w_sum_d;
            r_cout_q  <= w_cout_d;
            r_z_q     <= w_z_d;
            r_v_q     <= w_v_d;
            r_n_q     <= w_n_d;
            r_cmp_q   <= w_cmp_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_sum   = r_sum_q;
    assign o_cout  = r_cout_q;
    assign o_z     = r_z_q;
    assign o_v     = r_v_q;
    assign o_n     = r_n_q;
    assign o_cmp   = r_cmp_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_compare_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_compare_unit
//  Description : Self-checking bench for alu_compare_unit (WIDTH=16) using
//                directed vectors plus random operations against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_compare_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [2:0]   i_alu_fn;
    logic         o_valid;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_z;
    logic         o_v;
    logic         o_n;
    logic         o_cmp;

    int n_cmp = 0;
    int n_bad = 0;

    alu_compare_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_alu_fn (i_alu_fn),
        .o_valid  (o_valid),
        .o_sum    (o_sum),
        .o_cout   (o_cout),
        .o_z      (o_z),
        .o_v      (o_v),
        .o_n      (o_n),
        .o_cmp    (o_cmp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic. Overflow is "true signed result
    // does not fit in W bits"; signed less-than is "true result is negative".
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] fn,
                                  output logic [W-1:0] s, output logic co,
                                  output logic z, output logic v,
                                  output logic n, output logic cmp);
        logic [W-1:0] bb;
        int           uns;
        int           sgn;
        logic         lt;
        bb  = fn[0] ? ~b : b;
        uns = int'(a) + int'(bb) + int'(fn[0]);
        sgn = int'($signed(a)) + int'($signed(bb)) + int'(fn[0]);
        s   = uns[W-1:0];
        co  = uns[W];
        z   = (s == 0);
        n   = s[W-1];
        v   = (sgn > 32767) || (sgn < -32768);
        lt  = (sgn < 0);
        case (fn[2:1])
            2'b01:   cmp = z;
            2'b10:   cmp = lt;
            2'b11:   cmp = z | lt;
            default: cmp = 1'b0;
        endcase
    endfunction

    // Present one operation, clock it, and compare every output to the model.
    task automatic apply(input logic r, input logic vld, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] fn);
        logic [W-1:0] e_s;
        logic e_co, e_z, e_v, e_n, e_cmp, e_vld;
        @(negedge clk);
        rst      = r;
        i_valid  = vld;
        i_a      = a;
        i_b      = b;
        i_alu_fn = fn;
        model(a, b, fn, e_s, e_co, e_z, e_v, e_n, e_cmp);
        e_vld = vld;
        if (r) begin
            e_s = '0; e_co = 0; e_z = 0; e_v = 0; e_n = 0; e_cmp = 0; e_vld = 0;
        end
        @(posedge clk);
        #1;
        chk("valid", {31'd0, o_valid}, {31'd0, e_vld});
        chk("sum",   {16'd0, o_sum},   {16'd0, e_s});
        chk("cout",  {31'd0, o_cout},  {31'd0, e_co});
        chk("z",     {31'd0, o_z},     {31'd0, e_z});
        chk("v",     {31'd0, o_v},     {31'd0, e_v});
        chk("n",     {31'd0, o_n},     {31'd0, e_n});
        chk("cmp",   {31'd0, o_cmp},   {31'd0, e_cmp});
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_alu_fn = '0;

        // Reset with an operation presented: it must be discarded.
        apply(1'b1, 1'b1, 16'h1234, 16'h4321, 3'b101);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_sum",   {16'd0, o_sum},   32'd0);

        // First valid result right after reset release.
        apply(1'b0, 1'b1, 16'h0101, 16'h0011, 3'b101);
        chk("d20_sum", {16'd0, o_sum}, 32'h00F0);
        chk("d20_cmp", {31'd0, o_cmp}, 32'd0);
        chk("d20_valid", {31'd0, o_valid}, 32'd1);

        apply(1'b0, 1'b1, 16'hC0FF, 16'hEECC, 3'b101);
        chk("d21_sum", {16'd0, o_sum}, 32'hD233);
        chk("d21_n",   {31'd0, o_n},   32'd1);
        chk("d21_cmp", {31'd0, o_cmp}, 32'd1);

        apply(1'b0, 1'b1, 16'hA234, 16'h8000, 3'b101);
        chk("d22_sum", {16'd0, o_sum}, 32'h2234);
        chk("d22_cmp", {31'd0, o_cmp}, 32'd0);

        apply(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b101);
        chk("d23a_sum", {16'd0, o_sum}, 32'hFFFE);
        chk("d23a_cmp", {31'd0, o_cmp}, 32'd1);

        apply(1'b0, 1'b1, 16'h8000, 16'h0001, 3'b101);
        chk("d23b_sum", {16'd0, o_sum}, 32'h7FFF);
        chk("d23b_v",   {31'd0, o_v},   32'd1);
        chk("d23b_cmp", {31'd0, o_cmp}, 32'd1);

        // Equality with every compare select.
        apply(1'b0, 1'b1, 16'h1234, 16'h1234, 3'b011);
        chk("eq_z",   {31'd0, o_z},   32'd1);
        chk("eq_cmp", {31'd0, o_cmp}, 32'd1);
        apply(1'b0, 1'b1, 16'h1234, 16'h1234, 3'b111);
        chk("le_cmp", {31'd0, o_cmp}, 32'd1);
        apply(1'b0, 1'b1, 16'h1234, 16'h1234, 3'b101);
        chk("lt_cmp", {31'd0, o_cmp}, 32'd0);
        apply(1'b0, 1'b1, 16'h1234, 16'h1234, 3'b001);
        chk("none_cmp", {31'd0, o_cmp}, 32'd0);

        // Add-mode wrap to zero.
        apply(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b000);
        chk("add_sum",  {16'd0, o_sum},  32'h0000);
        chk("add_cout", {31'd0, o_cout}, 32'd1);
        chk("add_z",    {31'd0, o_z},    32'd1);

        // Back-to-back random operations, random valid and function.
        for (int k = 0; k < 300; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            apply(1'b0, 1'($urandom), ra, rb, 3'($urandom));
        end

        // Mid-stream reset, then resume.
        apply(1'b1, 1'b1, 16'h7FFF, 16'h8001, 3'b111);
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_cmp",   {31'd0, o_cmp},   32'd0);
        apply(1'b0, 1'b1, 16'h7FFF, 16'h8001, 3'b111);

        for (int k = 0; k < 50; k++) begin
            apply(1'b0, 1'b1, W'($urandom), W'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_compare_unit.md
ALU_COMPARE_UNIT -- requirements
Module: alu_compare_unit

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and >= 4.
REQ-002 Clocking: single clock clk; reset rst is synchronous and active-high.
REQ-003 Port list SHALL be exactly the following, one per line:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- i_valid  input  1  operands valid this cycle.
- i_a  input  WIDTH  operand A (two's complement).
- i_b  input  WIDTH  operand B (two's complement).
- i_alu_fn  input  3  bit0 = subtract select; bits[2:1] = compare select.
- o_valid  output  1  registered i_valid.
- o_sum  output  WIDTH  registered adder result.
- o_cout  output  1  registered adder carry-out.
- o_z  output  1  registered zero flag.
- o_v  output  1  registered signed-overflow flag.
- o_n  output  1  registered negative flag.
- o_cmp  output  1  registered compare result.

Function
REQ-004 Adder operand: b' = i_b XOR {WIDTH{i_alu_fn[0]}}; carry-in = i_alu_fn[0]; so bit0=0 gives A+B, bit0=1 gives A-B.
REQ-005 sum = (i_a + b' + cin) mod 2^WIDTH; cout = carry out of the MSB; computed with 4-bit carry-lookahead groups (generate/propagate), group carries rippled or looked ahead between groups.
REQ-006 z = 1 iff sum == 0.
REQ-007 v = (a[MSB] & b'[MSB] & ~sum[MSB]) | (~a[MSB] & ~b'[MSB] & sum[MSB]).
REQ-008 n = sum[MSB].
REQ-009 Compare select i_alu_fn[2:1]: 01 CMPEQ -> z; 10 CMPLT -> n XOR v; 11 CMPLE -> z OR (n XOR v); 00 -> 0.
REQ-010 Compare results are meaningful only with i_alu_fn[0]=1; with bit0=0 the formulas are still applied unchanged to the add result.
REQ-011 Latency: exactly 1 cycle; all outputs are registered together on the rising edge of clk.
REQ-012 Capture: operands and i_alu_fn are sampled every cycle regardless of i_valid; o_valid qualifies the outputs. There is no backpressure and no stall.
REQ-013 Back-to-back operations are accepted every cycle at full throughput.

Reset
REQ-014 While rst=1 at a clock edge, all outputs SHALL be 0 after that edge, including o_valid, o_sum, o_cout, o_z, o_v, o_n and o_cmp.
REQ-015 Reset has priority over capture; an operation presented in the same cycle as rst is discarded.
REQ-016 The first valid result appears one cycle after the first non-reset edge with i_valid=1.

Structure
REQ-017 Shared package alu_pkg SHALL hold the compare-select encodings (CMP_NONE=00, CMP_EQ=01, CMP_LT=10, CMP_LE=11) and the subtract-bit index.
REQ-018 One sub-module: carry_lookahead_adder (parameter WIDTH; ports cin, a, b, sum, cout; purely combinational).
REQ-019 Flag and compare logic stays inline; the output register stage is in the top module only.

Verification (WIDTH=16, i_alu_fn[0]=1, i_valid=1; response checked one cycle later)
REQ-020 a=0x0101, b=0x0011, CMPLT -> sum=0x00F0, z=0, v=0, n=0, cmp=0.
REQ-021 a=0xC0FF, b=0xEECC, CMPLT -> sum=0xD233, z=0, v=0, n=1, cmp=1.
REQ-022 a=0xA234, b=0x8000, CMPLT -> sum=0x2234, v=0, n=0, cmp=0.
REQ-023 a=0xFFFF, b=0x0001, CMPLT -> sum=0xFFFE, n=1, cmp=1; a=0x8000, b=0x0001 -> sum=0x7FFF, v=1, cmp=1 (overflow case).
REQ-024 Equality cases: a=b=0x1234 with CMPEQ -> z=1, cmp=1; same operands with CMPLE -> cmp=1; with CMPLT -> cmp=0; with sel=00 -> cmp=0.
REQ-025 Reset and add cases: assert rst mid-stream -> all outputs 0 on the next edge; add mode 0xFFFF+0x0001 -> sum=0x0000, cout=1, z=1.
